// File: rtl/map_frame_serializer_if.sv
// Byte-stream handshake from the frame serializer to the UART TX path.
// The master drives data/valid and the slave returns ready.
interface map_frame_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/map_frame_serializer.sv
// Streams one game-map frame per start: sync, two snake lengths, packed tile rows, checksum.
// Each row is latched into a buffer so its tiles stay mutually consistent while it is sent.
module map_frame_serializer #(
  parameter int unsigned MAP_W  = 64,
  parameter int unsigned MAP_H  = 48,
  parameter int unsigned TILE_W = 2,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic                                    clk_75,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic [MAP_H-1:0][MAP_W-1:0][TILE_W-1:0] map_tiles,
  input  logic [7:0]                              snake1_length,
  input  logic [7:0]                              snake2_length,
  output logic                                    busy,
  output logic                                    frame_done,
  map_frame_serializer_if.master                  tx
);

  localparam int unsigned PACK   = 8 / TILE_W;
  localparam int unsigned ROW_B  = MAP_W / PACK;
  localparam int unsigned ROW_W  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int unsigned BYTE_W = (ROW_B > 1) ? $clog2(ROW_B) : 1;
  localparam int unsigned ROW_BITS = MAP_W * TILE_W;

  localparam logic [ROW_W-1:0]  LastRow  = ROW_W'(MAP_H - 1);
  localparam logic [BYTE_W-1:0] LastByte = BYTE_W'(ROW_B - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHdrSync,
    StHdrL1,
    StHdrL2,
    StLoadRow,
    StRowTx,
    StCsum
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [7:0]          csum_q, csum_d;
  logic                done_q, done_d;
  logic                load_row;
  logic                xfer;
  logic [ROW_BITS-1:0] cur_row;
  logic [ROW_BITS-1:0] row_buf_q;

  assign xfer    = tx_valid_q && tx.tx_ready;
  assign cur_row = map_tiles[row_q];

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    row_d      = row_q;
    byte_d     = byte_q;
    csum_d     = csum_q;
    done_d     = 1'b0;
    load_row   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d    = StHdrSync;
          tx_data_d  = SYNC;
          tx_valid_d = 1'b1;
          row_d      = '0;
          byte_d     = '0;
          csum_d     = '0;
        end
      end
      StHdrSync: begin
        if (xfer) begin
          state_d   = StHdrL1;
          tx_data_d = snake1_length;
        end
      end
      StHdrL1: begin
        if (xfer) begin
          csum_d    = csum_q + tx_data_q;
          state_d   = StHdrL2;
          tx_data_d = snake2_length;
        end
      end
      StHdrL2: begin
        if (xfer) begin
          csum_d     = csum_q + tx_data_q;
          state_d    = StLoadRow;
          tx_valid_d = 1'b0;
        end
      end
      StLoadRow: begin
        // Byte 0 comes straight from the map; the buffer holds it from next cycle on.
        load_row   = 1'b1;
        state_d    = StRowTx;
        tx_data_d  = cur_row[7:0];
        tx_valid_d = 1'b1;
        byte_d     = '0;
      end
      StRowTx: begin
        if (xfer) begin
          csum_d = csum_q + tx_data_q;
          if (byte_q == LastByte) begin
            if (row_q == LastRow) begin
              state_d   = StCsum;
              tx_data_d = csum_d;
            end else begin
              row_d      = row_q + 1'b1;
              state_d    = StLoadRow;
              tx_valid_d = 1'b0;
            end
          end else begin
            byte_d    = byte_q + 1'b1;
            tx_data_d = row_buf_q[{byte_d, 3'b000} +: 8];
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          state_d    = StIdle;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        tx_valid_d = 1'b0;
      end
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      tx_valid_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_75 or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      row_q      <= '0;
      byte_q     <= '0;
      csum_q     <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      row_q      <= row_d;
      byte_q     <= byte_d;
      csum_q     <= csum_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk_75) begin
    if (load_row) begin
      row_buf_q <= cur_row;
    end
  end

  assign busy        = (state_q != StIdle);
  assign frame_done  = done_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_map_frame_serializer.sv
// Bench for map_frame_serializer: frames are compared against a byte list built from the
// tile array by plain arithmetic, under full-rate, stalled, restarted, aborted and reset runs.
module tb_map_frame_serializer;

  localparam int unsigned MAP_W     = 64;
  localparam int unsigned MAP_H     = 48;
  localparam int unsigned TILE_W    = 2;
  localparam int unsigned PACK      = 8 / TILE_W;
  localparam int unsigned ROW_B     = MAP_W / PACK;
  localparam int unsigned FRAME_LEN = 3 + MAP_H * ROW_B + 1;
  localparam logic [7:0]  SYNC      = 8'hA5;
  localparam logic [1:0]  T_EMPTY   = 2'd0;
  localparam logic [1:0]  T_POINT   = 2'd3;

  logic clk_75 = 1'b0;
  logic rst    = 1'b0;
  logic start  = 1'b0;
  logic abort  = 1'b0;
  logic busy;
  logic frame_done;
  logic [MAP_H-1:0][MAP_W-1:0][TILE_W-1:0] map_tiles;
  logic [7:0] l1;
  logic [7:0] l2;

  map_frame_serializer_if tx ();

  map_frame_serializer #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .TILE_W(TILE_W),
    .SYNC  (SYNC)
  ) dut (
    .clk_75       (clk_75),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .map_tiles    (map_tiles),
    .snake1_length(l1),
    .snake2_length(l2),
    .busy         (busy),
    .frame_done   (frame_done),
    .tx           (tx)
  );

  always #5 clk_75 = ~clk_75;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] tile_m [MAP_H][MAP_W];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int         done_cnt;
  int         gap_cnt;
  int         stall_viol;
  bit         stalled;
  logic [7:0] stall_data;
  int         ready_pct = 100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_map();
    for (int r = 0; r < MAP_H; r++)
      for (int c = 0; c < MAP_W; c++) tile_m[r][c] = T_EMPTY;
  endtask

  task automatic random_map();
    for (int r = 0; r < MAP_H; r++)
      for (int c = 0; c < MAP_W; c++) tile_m[r][c] = 2'($urandom_range(0, 3));
    l1 = 8'($urandom);
    l2 = 8'($urandom);
  endtask

  task automatic apply_map();
    for (int r = 0; r < MAP_H; r++)
      for (int c = 0; c < MAP_W; c++) map_tiles[r][c] = tile_m[r][c];
  endtask

  // Reference frame: sync, lengths, each byte = sum of tile << (TILE_W * position), checksum.
  task automatic build_expected();
    int sum;
    exp_q.delete();
    exp_q.push_back(SYNC);
    exp_q.push_back(l1);
    exp_q.push_back(l2);
    for (int r = 0; r < MAP_H; r++) begin
      for (int k = 0; k < ROW_B; k++) begin
        int v = 0;
        for (int i = 0; i < PACK; i++) v += int'(tile_m[r][k * PACK + i]) << (TILE_W * i);
        exp_q.push_back(8'(v));
      end
    end
    sum = 0;
    for (int i = 1; i < exp_q.size(); i++) sum += int'(exp_q[i]);
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic step();
    @(negedge clk_75);
    if (tx.tx_valid && tx.tx_ready) got.push_back(tx.tx_data);
    if (stalled && (tx.tx_valid !== 1'b1 || tx.tx_data !== stall_data)) stall_viol++;
    stalled    = tx.tx_valid && !tx.tx_ready;
    stall_data = tx.tx_data;
    if (frame_done) done_cnt++;
    if (busy && !tx.tx_valid) gap_cnt++;
    @(posedge clk_75);
    #1;
    tx.tx_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic begin_frame(input string tag);
    got.delete();
    done_cnt   = 0;
    gap_cnt    = 0;
    stall_viol = 0;
    stalled    = 0;
    start      = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_start_busy"}, busy, 1);
    chk({tag, "_start_valid"}, tx.tx_valid, 1);
    chk({tag, "_start_sync"}, tx.tx_data, SYNC);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_reach_byte"}, got.size() >= n, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_pulse"}, frame_done, 0);
  endtask

  task automatic check_frame(input string tag);
    int nerr = 0;
    chk({tag, "_len"}, got.size(), FRAME_LEN);
    if (got.size() == exp_q.size()) begin
      for (int i = 0; i < got.size(); i++) if (got[i] !== exp_q[i]) nerr++;
      chk({tag, "_bytes_bad"}, nerr, 0);
      chk({tag, "_csum"}, got[got.size() - 1], exp_q[exp_q.size() - 1]);
    end
  endtask

  initial begin
    tx.tx_ready = 1'b0;
    l1 = 8'd0;
    l2 = 8'd0;
    clear_map();
    apply_map();

    // Reset held with inputs toggling.
    for (int i = 0; i < 6; i++) begin
      start       = i[0];
      tx.tx_ready = ~i[0];
      @(negedge clk_75);
      chk("rst_busy", busy, 0);
      chk("rst_valid", tx.tx_valid, 0);
      chk("rst_data", tx.tx_data, 8'h00);
      @(posedge clk_75);
      #1;
    end
    start = 1'b0;
    rst   = 1'b1;
    tx.tx_ready = 1'b1;
    repeat (2) step();

    // Empty map, full rate.
    clear_map();
    l1 = 8'd3;
    l2 = 8'd5;
    apply_map();
    build_expected();
    ready_pct = 100;
    begin_frame("t2");
    wait_done("t2", 2000);
    check_frame("t2");
    chk("t2_gaps", gap_cnt, MAP_H);
    if (got.size() == FRAME_LEN) begin
      chk("t2_l1", got[1], 8'd3);
      chk("t2_l2", got[2], 8'd5);
      chk("t2_csum_const", got[FRAME_LEN - 1], 8'd8);
    end

    // Single POINT tile.
    tile_m[2][5] = T_POINT;
    apply_map();
    build_expected();
    begin_frame("t3");
    wait_done("t3", 2000);
    check_frame("t3");
    if (got.size() > 36) chk("t3_point", got[36][3:2], T_POINT);

    // Empty map with ~30% ready duty.
    clear_map();
    apply_map();
    build_expected();
    ready_pct = 30;
    begin_frame("t4");
    wait_done("t4", 12000);
    check_frame("t4");
    chk("t4_stall_stable", stall_viol, 0);
    chk("t4_gaps", gap_cnt, MAP_H);

    // start while busy is ignored.
    ready_pct = 100;
    random_map();
    apply_map();
    build_expected();
    begin_frame("t5");
    wait_bytes("t5", 100, 2000);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t5", 2000);
    check_frame("t5");
    repeat (20) step();
    chk("t5_no_second", got.size(), FRAME_LEN);
    chk("t5_idle", busy, 0);

    // abort mid-frame, restart 5 cycles later.
    ready_pct = 70;
    random_map();
    apply_map();
    begin_frame("t6a");
    wait_bytes("t6a", 200, 4000);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6a_abort_busy", busy, 0);
    chk("t6a_abort_valid", tx.tx_valid, 0);
    repeat (5) step();
    chk("t6a_no_done", done_cnt, 0);
    random_map();
    apply_map();
    build_expected();
    begin_frame("t6b");
    wait_done("t6b", 6000);
    check_frame("t6b");
    chk("t6b_stall_stable", stall_viol, 0);

    // Reset pulse mid-frame, restart.
    random_map();
    apply_map();
    begin_frame("t6c");
    wait_bytes("t6c", 200, 4000);
    rst = 1'b0;
    #2;
    chk("t6c_rst_valid", tx.tx_valid, 0);
    chk("t6c_rst_busy", busy, 0);
    chk("t6c_rst_data", tx.tx_data, 8'h00);
    step();
    rst = 1'b1;
    repeat (4) step();
    chk("t6c_no_done", done_cnt, 0);
    random_map();
    apply_map();
    build_expected();
    begin_frame("t6d");
    wait_done("t6d", 6000);
    check_frame("t6d");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
